// File: rtl/change_dispenser.sv
// change_dispenser: pays out the credit held by the vending state register.
// On a purchase it pulses the vend solenoid and pays change. On a coin return
// it pays back the whole credit. Coins go out one quarter at a time over a
// request/ack handshake with the hopper, and then the credit logic is told to
// clear back to S0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a purchase or coin-return request
// VEND      | one-cycle vend solenoid pulse
// PAYOUT    | hopper request held until ack (or timeout)
// GAP       | one-cycle low between coins so the hopper sees a fresh edge
// DONE      | one-cycle clear pulse to the credit logic
// FAULT     | sticky error, left only through reset
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   credit_i[6:0]  one-hot credit, bit k = k quarters
//   req_i          purchase request (sampled in IDLE only)
//   return_i       coin-return request (sampled in IDLE only, wins over req_i)
//   ack_i          hopper accepted one quarter (used in PAYOUT only)
//   vend_o         one-cycle vend pulse
//   disp_req_o     eject-one-quarter request to the hopper
//   clear_o        one-cycle clear-credit pulse
//   busy_o         high in every state except IDLE
//   fault_o        sticky fault
//   change_left_o  quarters still owed
module change_dispenser #(
  parameter int PRICE_QTRS  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] credit_i,
  input  logic       req_i,
  input  logic       return_i,
  input  logic       ack_i,
  output logic       vend_o,
  output logic       disp_req_o,
  output logic       clear_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic [2:0] change_left_o
);

  localparam logic [2:0] PRICE = 3'(PRICE_QTRS);
  localparam logic [7:0] TMO   = 8'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEND,
    ST_PAYOUT,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] change_q, change_d;
  logic [7:0] tmo_q, tmo_d;

  logic [2:0] credit_qtrs;
  logic       credit_onehot;
  logic [2:0] change_dec;
  logic [7:0] tmo_inc;

  // Credit decode; the one-hot test rejects both all-zero and multi-hot.
  always_comb begin
    credit_qtrs = '0;
    for (int k = 0; k < 7; k++) begin
      if (credit_i[k]) credit_qtrs = 3'(k);
    end
    credit_onehot = (credit_i != '0) && ((credit_i & (credit_i - 7'd1)) == '0);
  end

  assign change_dec = change_q - 3'd1;
  assign tmo_inc    = tmo_q + 8'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      change_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    change_d = change_q;
    tmo_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_i || return_i) begin
          if (!credit_onehot) begin
            state_d = ST_FAULT;
          end else if (return_i) begin
            change_d = credit_qtrs;
            state_d  = (credit_qtrs != '0) ? ST_PAYOUT : ST_DONE;
          end else if (credit_qtrs >= PRICE) begin
            change_d = credit_qtrs - PRICE;
            state_d  = ST_VEND;
          end
        end
      end
      ST_VEND: begin
        state_d = (change_q != '0) ? ST_PAYOUT : ST_DONE;
      end
      ST_PAYOUT: begin
        if (ack_i) begin
          change_d = change_dec;
          state_d  = (change_dec != '0) ? ST_GAP : ST_DONE;
        end else if (tmo_inc == TMO) begin
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_GAP:   state_d = ST_PAYOUT;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vend_o        = 1'b0;
    disp_req_o    = 1'b0;
    clear_o       = 1'b0;
    busy_o        = 1'b1;
    fault_o       = 1'b0;
    change_left_o = change_q;
    case (state_q)
      ST_IDLE:   busy_o     = 1'b0;
      ST_VEND:   vend_o     = 1'b1;
      ST_PAYOUT: disp_req_o = 1'b1;
      ST_DONE:   clear_o    = 1'b1;
      ST_FAULT:  fault_o    = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int PRICE   = 4;
  localparam int TIMEOUT = 15;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [6:0] credit_i;
  logic       req_i, return_i, ack_i;
  logic       vend_o, disp_req_o, clear_o, busy_o, fault_o;
  logic [2:0] change_left_o;

  int errors = 0;
  int checks = 0;

  change_dispenser #(.PRICE_QTRS(PRICE), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .credit_i(credit_i), .req_i(req_i),
    .return_i(return_i), .ack_i(ack_i), .vend_o(vend_o), .disp_req_o(disp_req_o),
    .clear_o(clear_o), .busy_o(busy_o), .fault_o(fault_o), .change_left_o(change_left_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    rst_n_i = 1'b0; credit_i = '0; req_i = 0; return_i = 0; ack_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; credit_i = '0; req_i = 0; return_i = 0; ack_i = 0;
    #3;
    checks++;
    if ({vend_o, disp_req_o, clear_o, busy_o, fault_o, change_left_o} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000000",
                         {vend_o, disp_req_o, clear_o, busy_o, fault_o, change_left_o});
    end
    do_reset();
    checks++;
    if (busy_o !== 1'b0 || fault_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: busy=%b fault=%b expected 0 0", busy_o, fault_o);
    end
  endtask

  // One complete transaction; the hopper acks after a random per-coin delay.
  // Expected behaviour is derived from the pricing rules and the per-coin
  // timing cost, not from any state sequence.
  task automatic run_txn(input string name, input logic [6:0] c, input bit req,
                         input bit ret, input int dlo, input int dhi);
    int qtrs, exp_q, exp_vend, busy_exp;
    bit active, done, prev_disp;
    int dly[7];
    int busy_cyc, vends, first_vend, first_disp, rises, acks, clears, clear_cyc, faults, wait_c;
    qtrs = 0;
    for (int k = 0; k < 7; k++) if (c[k]) qtrs = k;
    active = 0; exp_vend = 0; exp_q = 0;
    if (ret) begin active = 1; exp_q = qtrs; end
    else if (req && qtrs >= PRICE) begin active = 1; exp_vend = 1; exp_q = qtrs - PRICE; end
    busy_exp = 0;
    if (active) begin
      busy_exp = exp_vend + 1 + ((exp_q > 0) ? exp_q - 1 : 0);
      for (int k = 0; k < exp_q; k++) begin
        dly[k] = $urandom_range(dhi, dlo);
        busy_exp += dly[k] + 1;
      end
    end

    credit_i = c; req_i = req; return_i = ret;
    @(posedge clk_i); #1;
    req_i = 0; return_i = 0;

    done = 0; prev_disp = 0; busy_cyc = 0; vends = 0; first_vend = 0; first_disp = 0;
    rises = 0; acks = 0; clears = 0; clear_cyc = 0; faults = 0; wait_c = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (!busy_o) begin done = 1; break; end
      busy_cyc++;
      if (fault_o) faults++;
      if (vend_o) begin
        vends++;
        if (first_vend == 0) first_vend = cyc;
        checks++;
        if (change_left_o !== 3'(exp_q)) begin
          errors++; $display("FAIL %s vend_change_left: got %0d expected %0d", name, change_left_o, exp_q);
        end
      end
      if (clear_o) begin clears++; clear_cyc = cyc; end
      ack_i = 0;
      if (disp_req_o) begin
        if (!prev_disp) begin
          rises++; wait_c = 0;
          if (first_disp == 0) first_disp = cyc;
          checks++;
          if (change_left_o !== 3'(exp_q - acks)) begin
            errors++; $display("FAIL %s coin_change_left: got %0d expected %0d", name, change_left_o, exp_q - acks);
          end
        end
        if (wait_c >= ((acks < exp_q) ? dly[acks] : 0)) begin ack_i = 1; acks++; end
        else wait_c++;
      end else if ($urandom_range(3, 0) == 0) begin
        ack_i = 1;
      end
      prev_disp = disp_req_o;
      @(posedge clk_i); #1;
    end
    ack_i = 0;

    checks++;
    if (!done) begin errors++; $display("FAIL %s idle_timeout: busy still %b expected 0", name, busy_o); end
    checks++;
    if (busy_cyc != busy_exp) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc, busy_exp); end
    checks++;
    if (vends != exp_vend) begin errors++; $display("FAIL %s vend_count: got %0d expected %0d", name, vends, exp_vend); end
    if (exp_vend == 1) begin
      checks++;
      if (first_vend != 1) begin errors++; $display("FAIL %s vend_latency: got %0d expected 1", name, first_vend); end
    end
    checks++;
    if (rises != exp_q || acks != exp_q) begin
      errors++; $display("FAIL %s coins: got rises=%0d acks=%0d expected %0d", name, rises, acks, exp_q);
    end
    if (exp_q > 0) begin
      checks++;
      if (first_disp != exp_vend + 1) begin
        errors++; $display("FAIL %s first_disp: got %0d expected %0d", name, first_disp, exp_vend + 1);
      end
    end
    checks++;
    if (clears != int'(active)) begin errors++; $display("FAIL %s clear_count: got %0d expected %0d", name, clears, active); end
    if (active) begin
      checks++;
      if (clear_cyc != busy_cyc) begin errors++; $display("FAIL %s clear_last: got %0d expected %0d", name, clear_cyc, busy_cyc); end
    end
    checks++;
    if (faults != 0 || fault_o !== 1'b0) begin errors++; $display("FAIL %s no_fault: got %0d expected 0", name, faults); end
    checks++;
    if (change_left_o !== 3'd0) begin errors++; $display("FAIL %s idle_change_left: got %0d expected 0", name, change_left_o); end
  endtask

  task automatic test_exact_price();
    run_txn("exact_price", 7'b0010000, 1, 0, 0, 0);
  endtask

  task automatic test_change_payout();
    run_txn("change_payout", 7'b1000000, 1, 0, 1, 1);
  endtask

  task automatic test_insufficient_then_return();
    run_txn("insufficient", 7'b0001000, 1, 0, 0, 0);
    run_txn("return_with_req", 7'b0001000, 1, 1, 0, 2);
    run_txn("return_zero", 7'b0000001, 0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 30; t++) begin
      logic [6:0] c;
      int mode;
      c = 7'b1 << $urandom_range(6, 0);
      mode = $urandom_range(3, 0);
      run_txn($sformatf("rand%0d", t), c, mode == 0 || mode == 2, mode == 1 || mode == 2, 0, 3);
    end
  endtask

  task automatic check_sticky_fault(input string name, input logic [2:0] exp_left);
    checks++;
    if (fault_o !== 1'b1 || busy_o !== 1'b1 || vend_o !== 1'b0 || disp_req_o !== 1'b0 ||
        clear_o !== 1'b0 || change_left_o !== exp_left) begin
      errors++; $display("FAIL %s fault_state: got f=%b b=%b v=%b d=%b c=%b left=%0d expected 1 1 0 0 0 %0d",
                         name, fault_o, busy_o, vend_o, disp_req_o, clear_o, change_left_o, exp_left);
    end
    for (int i = 0; i < 6; i++) begin
      credit_i = 7'b1 << $urandom_range(6, 0);
      req_i = $urandom_range(1, 0); return_i = $urandom_range(1, 0); ack_i = $urandom_range(1, 0);
      @(posedge clk_i); #1;
    end
    req_i = 0; return_i = 0; ack_i = 0;
    checks++;
    if (fault_o !== 1'b1 || change_left_o !== exp_left) begin
      errors++; $display("FAIL %s fault_sticky: got f=%b left=%0d expected 1 %0d", name, fault_o, change_left_o, exp_left);
    end
  endtask

  task automatic test_fault_credit();
    credit_i = 7'b0000011; req_i = 1;
    @(posedge clk_i); #1;
    req_i = 0;
    check_sticky_fault("multihot", 3'd0);
    do_reset();
    credit_i = 7'b0000000; return_i = 1;
    @(posedge clk_i); #1;
    return_i = 0;
    check_sticky_fault("zero_credit", 3'd0);
    do_reset();
  endtask

  task automatic test_timeout();
    int disp_cnt;
    bit got;
    credit_i = 7'b0100000; req_i = 1;
    @(posedge clk_i); #1;
    req_i = 0;
    checks++;
    if (vend_o !== 1'b1) begin errors++; $display("FAIL timeout_vend: got %b expected 1", vend_o); end
    disp_cnt = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (fault_o) begin got = 1; break; end
      if (disp_req_o) disp_cnt++;
    end
    checks++;
    if (!got || disp_cnt != TIMEOUT) begin
      errors++; $display("FAIL timeout_len: got fault=%b after %0d req cycles expected 1 after %0d", got, disp_cnt, TIMEOUT);
    end
    check_sticky_fault("timeout", 3'd1);
    do_reset();
  endtask

  task automatic test_reset_mid_payout();
    int acks, clears;
    credit_i = 7'b1000000; return_i = 1;
    @(posedge clk_i); #1;
    return_i = 0;
    acks = 0;
    for (int i = 0; i < 60 && acks < 2; i++) begin
      ack_i = 0;
      if (disp_req_o) begin ack_i = 1; acks++; end
      @(posedge clk_i); #1;
    end
    ack_i = 0;
    checks++;
    if (acks != 2 || busy_o !== 1'b1 || change_left_o !== 3'd4) begin
      errors++; $display("FAIL midpay_progress: got acks=%0d busy=%b left=%0d expected 2 1 4", acks, busy_o, change_left_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({vend_o, disp_req_o, clear_o, busy_o, fault_o, change_left_o} !== 8'h00) begin
      errors++; $display("FAIL midpay_async_reset: got %b expected 00000000",
                         {vend_o, disp_req_o, clear_o, busy_o, fault_o, change_left_o});
    end
    @(posedge clk_i);
    @(negedge clk_i); rst_n_i = 1'b1;
    clears = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      if (clear_o || busy_o) clears++;
    end
    checks++;
    if (clears != 0) begin errors++; $display("FAIL midpay_after_release: got %0d active cycles expected 0", clears); end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change_payout();
    test_insufficient_then_return();
    test_back_to_back();
    test_fault_credit();
    test_timeout();
    test_reset_mid_payout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Paying end of the vending credit path.
- The state register accumulates credit one quarter at a time as one-hot S0..S6 ($0.00..$1.50). This block consumes that credit on a purchase or coin-return request.
- It issues the vend pulse, pays change out one quarter per handshake to the coin hopper, then commands the credit logic to clear back to S0.
- Sits between the state register outputs and the hopper/vend solenoid drivers.

Parameters:
- PRICE_QTRS, 4, item price in quarters (legal 1..6; default $1.00).
- ACK_TIMEOUT, 15, max cycles DISP_REQ may wait for ACK before FAULT (legal 1..255).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CREDIT  in  7  one-hot credit from the state register, bit k = S(k) = k quarters.
- REQ  in  1  purchase request, sampled only in IDLE.
- RETURN  in  1  coin-return request, sampled only in IDLE.
- ACK  in  1  hopper accepted one quarter; valid only while DISP_REQ=1.
- VEND  out  1  one-cycle release pulse to the vend solenoid.
- DISP_REQ  out  1  request hopper to eject one quarter; held until ACK.
- CLEAR  out  1  one-cycle pulse: credit logic returns to S0.
- BUSY  out  1  high in every state except IDLE.
- FAULT  out  1  sticky error; cleared only by RST_N.
- CHANGE_LEFT  out  3  quarters still to be paid out (0..6).

Behaviour:
- States: IDLE, VEND, PAYOUT, GAP, DONE, FAULT_ST. All outputs are Moore-decoded from registered state and registered change count.
- Reset (RST_N=0, any time, including mid-payout):
  - State goes to IDLE; all outputs 0; CHANGE_LEFT=0; timeout counter 0.
  - Unpaid change is discarded. No CLEAR is issued.
- IDLE, on each edge:
  - Decode CREDIT to count 0..6.
  - CREDIT not exactly one-hot (all-zero or multi-hot) while REQ or RETURN is high -> FAULT_ST.
  - RETURN=1 -> change=count, next state PAYOUT. Skip PAYOUT and go to DONE if count=0. RETURN has priority when REQ and RETURN are both high.
  - REQ=1 and count>=PRICE_QTRS -> change=count-PRICE_QTRS, next state VEND.
  - REQ=1 and count<PRICE_QTRS -> ignored; stay IDLE; no outputs; no fault.
  - CREDIT changes while neither request is high are ignored.
- VEND:
  - Exactly one cycle with VEND=1.
  - Next state PAYOUT if change>0, else DONE.
- PAYOUT:
  - DISP_REQ=1; the timeout counter increments each cycle.
  - ACK=1 -> change decrements by 1, counter resets. Next state GAP if the new change >0, else DONE.
  - Counter reaches ACK_TIMEOUT without ACK -> FAULT_ST.
- GAP:
  - One cycle with DISP_REQ=0. This guarantees a low gap between coins so the hopper sees a distinct edge.
  - Then back to PAYOUT.
- DONE:
  - One cycle with CLEAR=1, then IDLE. New requests are accepted on the following edge.
- FAULT_ST:
  - FAULT=1, BUSY=1; VEND, DISP_REQ and CLEAR are 0. CHANGE_LEFT holds its last value.
  - Exit only via RST_N.
- ACK outside PAYOUT is ignored. Requests outside IDLE are ignored (not queued).
- Latency:
  - REQ sampled at edge N -> VEND high cycle N+1 -> first DISP_REQ at N+2.
  - Each paid quarter costs at least 2 cycles (PAYOUT with ACK, plus GAP).
- Width: change count 3 bits unsigned. Underflow is impossible by construction: subtraction occurs only when count>=PRICE_QTRS, and decrement only when change>0.

Test Plan:
- Reset mid-payout:
  - Stimulus: CREDIT=S6, RETURN pulse; assert RST_N=0 after the second ACK.
  - Required: all outputs 0 immediately (asynchronous); IDLE after release; no CLEAR.
- Exact price:
  - Stimulus: CREDIT=S4 (0010000b), REQ pulse.
  - Required: VEND one cycle at N+1, CLEAR at N+2, DISP_REQ never high, BUSY high for 2 cycles.
- Change payout:
  - Stimulus: CREDIT=S6, REQ; ACK 1 cycle after each DISP_REQ rise.
  - Required: VEND once; CHANGE_LEFT 2->1->0; DISP_REQ high twice separated by a 1-cycle low; CLEAR after the second ACK.
- Insufficient credit, then coin return:
  - Stimulus: CREDIT=S3, REQ.
  - Required: no response, BUSY stays 0.
  - Stimulus: then RETURN together with REQ.
  - Required: no VEND, 3 quarters dispensed, then CLEAR.
- Fault paths:
  - Stimulus: CREDIT=0000011b with REQ.
  - Required: FAULT=1, sticky.
  - Stimulus: separately, CREDIT=S5, REQ, ACK withheld.
  - Required: FAULT asserts exactly ACK_TIMEOUT=15 cycles into PAYOUT; DISP_REQ drops; CHANGE_LEFT=1 holds.
